rank_change_logger: RTL and testbench

- Downstream consumer of the running second-largest tracker. Samples the tracker's dout every cycle and detects when the value changes.
- Each change is recorded as an event (new value, cycle stamp) in a small FIFO.
- Events drain through a valid/ready port toward a debug/trace sink. The block converts a per-cycle level stream into sparse, back-pressurable events.

---
 rtl/rank_pkg.sv | 19 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/rank_change_logger.sv | 94 +++++++++
 tb/tb_rank_change_logger.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rank_pkg.sv
// Shared types and default sizing for the rank change logger.
package rank_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_STAMP_WIDTH = 16;
  localparam int DEF_DEPTH       = 8;

  // One logged change at the default sizing: new value plus its cycle stamp.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]  value;
    logic [DEF_STAMP_WIDTH-1:0] stamp;
  } rank_event_t;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with register storage, exact occupancy count and
// synchronous clear. A push is accepted when not full, or when full and a pop
// is performed in the same cycle.
module sync_fifo
  import rank_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + DEF_STAMP_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  // Head entry is held in a register, so there is no path from wdata to rdata.
  assign rdata   = mem[rd_ptr];

  // Storage: cleared on reset/clear so a discarded head reads back as zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rank_change_logger.sv
// Watches the tracker output every cycle, logs each change as (value, stamp)
// into a small FIFO, and drains the events through a valid/ready port.
module rank_change_logger
  import rank_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int STAMP_WIDTH = DEF_STAMP_WIDTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_value,
  output logic [STAMP_WIDTH-1:0]       out_stamp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  value;
    logic [STAMP_WIDTH-1:0] stamp;
  } event_t;

  localparam int EW = DATA_WIDTH + STAMP_WIDTH;

  logic [DATA_WIDTH-1:0]  prev_q;
  logic [STAMP_WIDTH-1:0] stamp_q;
  logic                   overflow_q;
  logic                   change;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  event_t                 wr_event;
  event_t                 head_event;
  logic [EW-1:0]          head_bits;

  // A change is any difference from the last sampled value; clear suppresses it.
  assign change   = (din != prev_q);
  assign push     = change && !clear;
  assign pop      = out_valid && out_ready && !clear;
  assign wr_event = '{value: din, stamp: stamp_q};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .push   (push),
    .wdata  (wr_event),
    .pop    (pop),
    .rdata  (head_bits),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign head_event = event_t'(head_bits);
  assign out_valid  = !fifo_empty;
  assign out_value  = head_event.value;
  assign out_stamp  = head_event.stamp;
  assign overflow   = overflow_q;

  // Last sampled tracker value and free-running cycle stamp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q  <= '0;
      stamp_q <= '0;
    end else if (clear) begin
      prev_q  <= '0;
      stamp_q <= '0;
    end else begin
      prev_q  <= din;
      stamp_q <= stamp_q + 1'b1;
    end
  end

  // Sticky drop flag: set when a change arrives at a full FIFO with no pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rank_change_logger.sv
// Directed bench for rank_change_logger: default instance plus a 4-bit stamp
// instance for wrap and asynchronous reset checks.
module tb_rank_change_logger;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clear;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [15:0] out_stamp;
  logic [3:0]  count;
  logic        overflow;

  logic        resetn4;
  logic        clear4;
  logic [31:0] din4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] out_value4;
  logic [3:0]  out_stamp4;
  logic [3:0]  count4;
  logic        overflow4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rank_change_logger #(.DATA_WIDTH(32), .STAMP_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_stamp(out_stamp), .count(count), .overflow(overflow)
  );

  rank_change_logger #(.DATA_WIDTH(32), .STAMP_WIDTH(4), .DEPTH(8)) dut4 (
    .clk(clk), .resetn(resetn4), .clear(clear4), .din(din4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_value(out_value4),
    .out_stamp(out_stamp4), .count(count4), .overflow(overflow4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    clear     = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);
    check("rst_value", 64'(out_value), 64'd0);
    check("rst_stamp", 64'(out_stamp), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [31:0] seq2 [5];
  logic        vexp2 [5];

  initial begin
    resetn4    = 1'b0;
    clear4     = 1'b0;
    din4       = '0;
    out_ready4 = 1'b0;

    // Idle: din held at zero produces no events.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 64'(out_valid), 64'd0);
    end
    check("idle_count", 64'(count), 64'd0);
    check("idle_ovf",   64'(overflow), 64'd0);

    // Basic change detection with a ready sink.
    do_reset();
    out_ready = 1'b1;
    seq2  = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd9};
    vexp2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      din = seq2[k];
      tick();
      check("basic_valid", 64'(out_valid), 64'(vexp2[k]));
    end
    din = 32'd9;
    tick();
    check("basic_drained", 64'(out_valid), 64'd0);
    // Re-run to capture the head values at the moments they are visible.
    do_reset();
    out_ready = 1'b0;
    din = 0; tick(); tick();
    din = 5; tick();
    check("basic_v5",  64'(out_value), 64'd5);
    check("basic_s2",  64'(out_stamp), 64'd2);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; din = 9; tick();
    check("basic_v9",  64'(out_value), 64'd9);
    check("basic_s4",  64'(out_stamp), 64'd4);

    // Overflow: ten changes with a stalled sink.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      din = 32'(k + 1);
      tick();
    end
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_flag",  64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_valid", 64'(out_valid), 64'd1);
      check("ovf_drain_value", 64'(out_value), 64'(i + 1));
      check("ovf_drain_stamp", 64'(out_stamp), 64'(i));
      tick();
    end
    check("ovf_empty", 64'(count), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Clear with events queued and overflow set.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      din = 32'(k);
      tick();
    end
    check("clr_pre_count", 64'(count), 64'd3);
    clear = 1'b1;
    din   = 32'd7;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    check("clr_count", 64'(count), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_ovf",   64'(overflow), 64'd0);
    check("clr_value", 64'(out_value), 64'd0);
    tick();
    check("clr_ev_valid", 64'(out_valid), 64'd1);
    check("clr_ev_value", 64'(out_value), 64'd7);
    check("clr_ev_stamp", 64'(out_stamp), 64'd0);
    tick();
    check("clr_hold_count", 64'(count), 64'd1);

    // Full FIFO with a change and a pop in the same cycle.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      din = 32'(k + 1);
      tick();
    end
    check("fpp_full", 64'(count), 64'd8);
    din = 32'd99;
    out_ready = 1'b1;
    tick();
    check("fpp_count", 64'(count), 64'd8);
    check("fpp_ovf",   64'(overflow), 64'd0);
    for (int i = 0; i < 7; i++) begin
      check("fpp_value", 64'(out_value), 64'(i + 2));
      check("fpp_stamp", 64'(out_stamp), 64'(i + 1));
      tick();
    end
    check("fpp_last_value", 64'(out_value), 64'd99);
    check("fpp_last_stamp", 64'(out_stamp), 64'd8);
    tick();
    check("fpp_empty", 64'(out_valid), 64'd0);

    // Stamp wrap on the 4-bit instance and asynchronous reset.
    @(negedge clk);
    resetn4 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      din4 = (k >= 17) ? 32'd2 : ((k >= 15) ? 32'd1 : 32'd0);
      tick();
    end
    check("wrap_count", 64'(count4), 64'd2);
    check("wrap_s15",   64'(out_stamp4), 64'd15);
    check("wrap_v1",    64'(out_value4), 64'd1);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("wrap_s1", 64'(out_stamp4), 64'd1);
    check("wrap_v2", 64'(out_value4), 64'd2);
    check("wrap_pre_rst_valid", 64'(out_valid4), 64'd1);
    #2;
    resetn4 = 1'b0;
    #1;
    check("async_valid", 64'(out_valid4), 64'd0);
    check("async_count", 64'(count4), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
